// File: rtl/ssd_capture_if.sv
// Seven-segment display bus plus the reconstructed-frame outputs of the capture monitor.
// Pure wiring bundle, no latency of its own.
// No backpressure: the display bus is free-running and the frame outputs are one-cycle pulses.
interface ssd_capture_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   anode;
  logic [6:0]          cathode;
  logic [4*DIGITS-1:0] digit_codes;
  logic                frame_valid;
  logic                bad_pattern;
  logic                anode_err;

  // Display driver side (or bench): drives the scan bus, observes the monitor
  modport master (
    output anode, cathode,
    input  digit_codes, frame_valid, bad_pattern, anode_err
  );

  // Capture monitor side: samples the scan bus, publishes decoded frames
  modport slave (
    input  anode, cathode,
    output digit_codes, frame_valid, bad_pattern, anode_err
  );
endinterface

// File: rtl/ssd_capture.sv
// Loopback monitor: decodes a multiplexed active-low 7-seg scan back into per-position codes.
// Latency: capture STABLE_CYCLES-1 edges after a sample first appears, publish one edge later.
// No backpressure: inputs are always sampled; outputs are single-cycle pulses plus a held frame.
module ssd_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  ssd_capture_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int ZW = $clog2(DIGITS + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                w_capture;

  logic [DIGITS-1:0]   r_prev_anode;
  logic [6:0]          r_prev_cath;
  logic                r_prev_multi;

  logic [ZW-1:0]       w_zeros;
  logic [IW-1:0]       w_idx;
  logic                w_valid;
  logic                w_multi;
  logic                w_same;
  logic [3:0]          w_code;
  logic                w_publish;
  logic [DIGITS-1:0]   w_seen_nxt;

  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_codes;
  logic                r_fv;
  logic                r_bad;
  logic                r_aerr;

  // Inverse of the BCD-to-segment table; bit6 = a ... bit0 = g, active low
  function automatic logic [3:0] seg_decode(input logic [6:0] c);
    logic [3:0] d;
    case (c)
      7'b0000001: d = 4'd0;
      7'b1001111: d = 4'd1;
      7'b0010010: d = 4'd2;
      7'b0000110: d = 4'd3;
      7'b1001100: d = 4'd4;
      7'b0100100: d = 4'd5;
      7'b0100000: d = 4'd6;
      7'b0001111: d = 4'd7;
      7'b0000000: d = 4'd8;
      7'b0000100: d = 4'd9;
      7'b1111110: d = 4'd10;  // minus
      7'b1111111: d = 4'd11;  // blank
      default:    d = 4'hF;   // undecodable
    endcase
    return d;
  endfunction

  // Classify the anode: count low bits and remember which one was low
  always_comb begin
    w_zeros = '0;
    w_idx   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bus.anode[i]) begin
        w_zeros = w_zeros + 1'b1;
        w_idx   = i[IW-1:0];
      end
    end
  end

  assign w_valid   = (w_zeros == ZW'(1));
  assign w_multi   = (w_zeros > ZW'(1));
  assign w_same    = (bus.anode == r_prev_anode) && (bus.cathode == r_prev_cath);
  assign w_code    = seg_decode(bus.cathode);
  assign w_publish = &r_seen;

  // Stability FSM: next state, counter and capture strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    if (!w_valid) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_TRACK;
          w_cnt_nxt   = CW'(1);
        end
        ST_TRACK: begin
          if (!w_same) begin
            w_cnt_nxt = CW'(1);
          end else if (r_cnt >= CW'(STABLE_CYCLES - 1)) begin
            // Counter lands on STABLE_CYCLES and stays there while held
            w_capture   = 1'b1;
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = CW'(STABLE_CYCLES);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_same) begin
            w_state_nxt = ST_TRACK;
            w_cnt_nxt   = CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Mask update: publish clears it, but a capture on the same edge still lands
  always_comb begin
    w_seen_nxt = w_publish ? '0 : r_seen;
    if (w_capture) w_seen_nxt[w_idx] = 1'b1;
  end

  // FSM state and stability counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Previous-sample history and edge-detected multi-low anode error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_anode <= '1;
      r_prev_cath  <= '1;
      r_prev_multi <= 1'b0;
      r_aerr       <= 1'b0;
    end else begin
      r_prev_anode <= bus.anode;
      r_prev_cath  <= bus.cathode;
      r_prev_multi <= w_multi;
      r_aerr       <= w_multi & ~r_prev_multi;
    end
  end

  // Shadow capture, mask tracking and atomic frame publish
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seen   <= '0;
      r_shadow <= {DIGITS{4'hB}};
      r_codes  <= {DIGITS{4'hB}};
      r_fv     <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_seen <= w_seen_nxt;
      r_fv   <= w_publish;
      r_bad  <= w_capture && (w_code == 4'hF);
      if (w_publish) r_codes <= r_shadow;
      for (int k = 0; k < DIGITS; k++) begin
        if (w_capture && (w_idx == k[IW-1:0])) r_shadow[4*k +: 4] <= w_code;
      end
    end
  end

  assign bus.digit_codes = r_codes;
  assign bus.frame_valid = r_fv;
  assign bus.bad_pattern = r_bad;
  assign bus.anode_err   = r_aerr;

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture: scans frames on the display bus and scoreboards published codes.
// Frames are queued when scanned; the monitor pops one per frame_valid and tracks pulses.
// No backpressure on the DUT; all waits are fixed cycle counts.
module tb_ssd_capture;

  localparam int DIGITS = 4;
  localparam int S      = 4;

  logic clk;
  logic reset_n;

  ssd_capture_if #(.DIGITS(DIGITS)) bus ();

  ssd_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fv_cnt   = 0;
  int          fv_cyc   = -1;
  int          bad_cnt  = 0;
  int          bad_cyc  = -1;
  int          err_cnt  = 0;
  int          err_cyc  = -1;
  logic [15:0] model    = 16'hBBBB;
  logic [15:0] q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Forward segment table, independent of the DUT decode
  function automatic logic [6:0] seg(input int d);
    logic [6:0] c;
    case (d)
      0:  c = 7'b0000001;
      1:  c = 7'b1001111;
      2:  c = 7'b0010010;
      3:  c = 7'b0000110;
      4:  c = 7'b1001100;
      5:  c = 7'b0100100;
      6:  c = 7'b0100000;
      7:  c = 7'b0001111;
      8:  c = 7'b0000000;
      9:  c = 7'b0000100;
      10: c = 7'b1111110;
      default: c = 7'b1111111;
    endcase
    return c;
  endfunction

  // Monitor: scoreboard pop on frame_valid, codes must hold between publishes
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      model = 16'hBBBB;
      chk("rst_codes", bus.digit_codes, 16'hBBBB);
      chk("rst_pulses", {bus.frame_valid, bus.bad_pattern, bus.anode_err}, 3'b000);
    end else begin
      if (bus.frame_valid) begin
        fv_cnt++;
        fv_cyc = cyc;
        chk("frame_expected", q.size() != 0, 1);
        if (q.size() != 0) model = q.pop_front();
      end
      chk("codes", bus.digit_codes, model);
      if (bus.bad_pattern) begin
        bad_cnt++;
        bad_cyc = cyc;
      end
      if (bus.anode_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] c, input int n);
    bus.anode   = an;
    bus.cathode = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int pos, input logic [6:0] c, input int n);
    logic [3:0] one;
    one = 4'b0001;
    drive(~(one << pos), c, n);
  endtask

  initial begin
    int f0, b0, e0, s, s1, fs;
    reset_n     = 1'b1;
    bus.anode   = 4'hF;
    bus.cathode = 7'h7F;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset_codes", bus.digit_codes, 16'hBBBB);
    chk("reset_fv", bus.frame_valid, 1'b0);
    chk("reset_bad", bus.bad_pattern, 1'b0);
    chk("reset_aerr", bus.anode_err, 1'b0);
    reset_n = 1'b1;
    repeat (3 * S) @(negedge clk);
    chk("idle_no_frame", fv_cnt, 0);
    chk("idle_codes", bus.digit_codes, 16'hBBBB);

    // Normal scan "1","2","-","3"
    q.push_back(16'h3A21);
    f0 = fv_cnt;
    show(0, seg(1), 6);
    show(1, seg(2), 6);
    show(2, seg(10), 6);
    s = cyc;
    show(3, seg(3), 6);
    drive(4'hF, 7'h7F, 2);
    chk("scan_frames", fv_cnt - f0, 1);
    chk("scan_fv_time", fv_cyc, s + S + 1);
    chk("scan_codes", bus.digit_codes, 16'h3A21);

    // Glitch on position 2 must not count
    q.push_back(16'h6754);
    f0 = fv_cnt;
    show(0, seg(4), 6);
    show(1, seg(5), 6);
    show(2, seg(8), S - 1);
    show(3, seg(6), 6);
    chk("glitch_no_frame", fv_cnt - f0, 0);
    chk("glitch_codes_hold", bus.digit_codes, 16'h3A21);
    s = cyc;
    show(2, seg(7), 6);
    drive(4'hF, 7'h7F, 2);
    chk("glitch_frames", fv_cnt - f0, 1);
    chk("glitch_fv_time", fv_cyc, s + S + 1);
    chk("glitch_codes", bus.digit_codes, 16'h6754);

    // Undecodable pattern on position 1
    q.push_back(16'hB0F9);
    f0 = fv_cnt;
    b0 = bad_cnt;
    show(0, seg(9), 6);
    s1 = cyc;
    show(1, 7'b1010101, 6);
    show(2, seg(0), 6);
    s = cyc;
    show(3, seg(11), 6);
    drive(4'hF, 7'h7F, 2);
    chk("bad_pulses", bad_cnt - b0, 1);
    chk("bad_time", bad_cyc, s1 + S);
    chk("bad_frames", fv_cnt - f0, 1);
    chk("bad_fv_time", fv_cyc, s + S + 1);
    chk("bad_codes", bus.digit_codes, 16'hB0F9);

    // Multi-low anode fault mid-frame
    q.push_back(16'h4321);
    f0 = fv_cnt;
    e0 = err_cnt;
    show(0, seg(1), 6);
    show(1, seg(2), 6);
    fs = cyc;
    drive(4'b0011, seg(8), 5);
    chk("aerr_pulses", err_cnt - e0, 1);
    chk("aerr_time", err_cyc, fs + 1);
    chk("aerr_no_frame", fv_cnt - f0, 0);
    show(2, seg(3), 6);
    s = cyc;
    show(3, seg(4), 6);
    drive(4'hF, 7'h7F, 2);
    chk("aerr_frames", fv_cnt - f0, 1);
    chk("aerr_fv_time", fv_cyc, s + S + 1);
    chk("aerr_codes", bus.digit_codes, 16'h4321);

    // Reset mid-frame discards partial shadow and mask
    f0 = fv_cnt;
    show(0, seg(5), 6);
    show(1, seg(6), 6);
    reset_n   = 1'b0;
    bus.anode = 4'hF;
    repeat (2) @(negedge clk);
    chk("midrst_codes", bus.digit_codes, 16'hBBBB);
    reset_n = 1'b1;
    drive(4'hF, 7'h7F, 2);
    chk("midrst_no_frame", fv_cnt - f0, 0);
    q.push_back(16'h8888);
    show(0, seg(8), 6);
    show(1, seg(8), 6);
    show(2, seg(8), 6);
    s = cyc;
    show(3, seg(8), 6);
    drive(4'hF, 7'h7F, 3);
    chk("midrst_frames", fv_cnt - f0, 1);
    chk("midrst_fv_time", fv_cyc, s + S + 1);
    chk("midrst_codes_8888", bus.digit_codes, 16'h8888);
    chk("queue_drained", q.size(), 0);
    chk("total_bad", bad_cnt, 1);
    chk("total_aerr", err_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_capture.md
# ssd_capture

Seven-segment scan capture block: watches a multiplexed, active-low four-digit display bus (anode select plus seven cathodes) and reconstructs the digit code shown on each position. It inverts the team's BCD-to-segment mapping, including minus and blank, and publishes one complete, consistent frame of codes at a time. It sits on the display output path as a loopback monitor, so benches and on-chip self-test can read back what the ALU display is actually showing.

## Interface
- DIGITS, 4: number of multiplexed digit positions.
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured. Minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- anode  in  DIGITS  active-low digit select; bit k low means position k is driven.
- cathode  in  7  active-low segments; bit6 = a, bit0 = g.
- digit_codes  out  4*DIGITS  published codes; nibble k = position k.
- frame_valid  out  1  one-cycle pulse when digit_codes updates.
- bad_pattern  out  1  one-cycle pulse when an undecodable cathode pattern is captured.
- anode_err  out  1  one-cycle pulse on the first cycle of a multi-low anode sample.

## Operation
- Inputs are synchronous to clk (internal loopback). There is no synchronizer.
- Decode table, cathode to code:
  - 0000001 → 0, 1001111 → 1, 0010010 → 2, 0000110 → 3, 1001100 → 4
  - 0100100 → 5, 0100000 → 6, 0001111 → 7, 0000000 → 8, 0000100 → 9
  - 1111110 → 10 (minus), 1111111 → 11 (blank)
  - any other pattern → 4'hF and a bad_pattern pulse.
- anode classification: exactly one low bit is valid, index k. All high is idle. Two or more low bits is an error.
- FSM states:
  - IDLE: no valid anode. Stability counter at 0.
  - TRACK: counting identical samples of (anode, cathode).
  - HELD: digit captured; waiting for any input change.
- FSM transitions:
  - IDLE → TRACK: valid anode sampled; counter = 1.
  - TRACK, same sample: counter increments. When counter reaches STABLE_CYCLES, capture on that edge and go to HELD.
  - TRACK or HELD, changed but still valid sample: go to TRACK, counter = 1. No capture.
  - Any state, invalid or idle anode: go to IDLE, counter = 0.
  - HELD persists while the sample is unchanged; a held pattern is never captured twice.
- Capture: write the decoded code into shadow slot k and set seen_mask[k].
  - Recapturing a position already in seen_mask overwrites the shadow; the mask is unchanged.
- Publish: on the edge after seen_mask becomes all ones:
  - copy the shadow into digit_codes;
  - pulse frame_valid;
  - clear seen_mask.
- A capture landing on the publish edge sets its bit in the new (cleared) mask.
- Published codes are atomic: digit_codes never mixes two frames and changes only on publish.
- anode_err pulses once per entry into the multi-low condition, not every cycle it persists.

## Timing
- Reset values (async assert; deassert synchronous to clk):
  - digit_codes = all nibbles 4'hB (blank);
  - frame_valid, bad_pattern, anode_err = 0;
  - seen_mask = 0; shadow = all 4'hB; FSM = IDLE; counter = 0.
- Capture latency: a sample first seen at edge t and unchanged through edge t+STABLE_CYCLES−1 is captured at edge t+STABLE_CYCLES−1.
- bad_pattern pulses in the cycle after that capture edge.
- Publish latency: publish occurs one edge after the capture that completes the mask.
- Minimum scan dwell per digit is STABLE_CYCLES cycles. Shorter dwells or glitches are never captured.
- The counter saturates at STABLE_CYCLES and never wraps.
- Reset mid-frame discards the partial shadow and mask; digit_codes returns to blank.

## Test plan
- Reset: hold reset_n low, then release. Required: digit_codes = 16'hBBBB, all pulses 0, no frame_valid for 3·STABLE_CYCLES idle cycles.
- Normal scan: drive "1","2","-","3" on positions 0..3, 6 cycles each. Required: a single frame_valid, one edge after digit 3's capture; digit_codes = 16'h3A21.
- Glitch rejection: during scan, drive position 2 for 3 cycles (< STABLE_CYCLES) with 0000000. Required: no capture; digit_codes unchanged; the next frame needs a proper dwell on position 2.
- Bad pattern: position 1 shows cathode 1010101 for 6 cycles. Required: bad_pattern pulses once; the frame publishes with nibble 1 = 4'hF.
- Anode fault: anode = 4'b0011 for 5 cycles mid-frame. Required: anode_err pulses once; no capture; seen_mask keeps earlier digits; the frame completes after the remaining digits.
- Mid-frame reset: capture 2 digits, assert reset_n, release, scan a full frame "8888". Required: one frame_valid; digit_codes = 16'h8888; no stale nibbles.
